// File: rtl/execute_cycle_simd.sv
// Execute stage of the SIMD pipeline: lane-wise ALU, branch resolution and a
// group-serial lane multiplier / multiply-accumulator that stalls fetch and decode.
module execute_cycle_simd #(
  parameter int unsigned DATA_W          = 256,
  parameter int unsigned LANE_W          = 16,
  parameter int unsigned LANES_PER_CYCLE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] RD1E,
  input  logic [DATA_W-1:0] RD2E,
  input  logic [DATA_W-1:0] ImmExtE,
  input  logic [DATA_W-1:0] PCE,
  input  logic [DATA_W-1:0] PCPlus4E,
  input  logic [4:0]        RDE,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              BranchE,
  input  logic              ALUSrcE,
  input  logic              ResultSrcE,
  input  logic [2:0]        ALUControlE,
  output logic              PCSrcE,
  output logic [DATA_W-1:0] PCTargetE,
  output logic              StallE,
  output logic [DATA_W-1:0] ALUResultM,
  output logic [DATA_W-1:0] WriteDataM,
  output logic [DATA_W-1:0] PCPlus4M,
  output logic [4:0]        RDM,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic              ResultSrcM
);

  localparam int unsigned LANES = DATA_W / LANE_W;
  localparam int unsigned NGRP  = LANES / LANES_PER_CYCLE;
  localparam int unsigned GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              r_state, w_state_nxt;
  logic [GRP_W-1:0]    r_grp;
  logic [DATA_W-1:0]   r_a, r_b, r_acc, r_buf;
  logic                r_mac;
  logic [DATA_W-1:0]   w_src_b, w_alu, w_buf_grp, w_acc_grp;
  logic                w_is_mul, w_zero, w_lt;

  assign w_src_b   = ALUSrcE ? ImmExtE : RD2E;
  assign w_is_mul  = (ALUControlE[2:1] == 2'b11);
  assign w_lt      = $signed(RD1E[31:0]) < $signed(w_src_b[31:0]);
  assign w_zero    = (w_alu == '0);
  assign PCTargetE = PCE + ImmExtE;
  assign PCSrcE    = BranchE & w_zero & (r_state == StIdle);

  // Single-cycle ALU; mul ops yield 0 here since their result comes from r_buf.
  always_comb begin
    w_alu = '0;
    unique case (ALUControlE)
      3'b000: for (int i = 0; i < int'(LANES); i++)
                w_alu[i*LANE_W +: LANE_W] = RD1E[i*LANE_W +: LANE_W] + w_src_b[i*LANE_W +: LANE_W];
      3'b001: for (int i = 0; i < int'(LANES); i++)
                w_alu[i*LANE_W +: LANE_W] = RD1E[i*LANE_W +: LANE_W] - w_src_b[i*LANE_W +: LANE_W];
      3'b010: w_alu = RD1E & w_src_b;
      3'b011: w_alu = RD1E | w_src_b;
      3'b101: w_alu = {{(DATA_W-1){1'b0}}, w_lt};
      default: w_alu = '0;
    endcase
  end

  // One multiplier group per cycle; low 16 bits are sign-agnostic.
  always_comb begin : mul_grp
    int unsigned       idx;
    logic [LANE_W-1:0] prod;
    logic [LANE_W-1:0] macv;
    idx       = 0;
    prod      = '0;
    macv      = '0;
    w_buf_grp = r_buf;
    w_acc_grp = r_acc;
    for (int j = 0; j < int'(LANES_PER_CYCLE); j++) begin
      idx  = int'(r_grp) * LANES_PER_CYCLE + j;
      prod = r_a[idx*LANE_W +: LANE_W] * r_b[idx*LANE_W +: LANE_W];
      macv = r_acc[idx*LANE_W +: LANE_W] + prod;
      w_acc_grp[idx*LANE_W +: LANE_W] = macv;
      w_buf_grp[idx*LANE_W +: LANE_W] = r_mac ? macv : prod;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    StallE      = 1'b0;
    unique case (r_state)
      StIdle: begin
        StallE = w_is_mul;
        if (w_is_mul) w_state_nxt = StBusy;
      end
      StBusy: begin
        StallE = 1'b1;
        if (r_grp == GRP_W'(NGRP - 1)) w_state_nxt = StDone;
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) r_state <= StIdle;
    else      r_state <= w_state_nxt;
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_grp      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_buf      <= '0;
      r_mac      <= 1'b0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      RDM        <= '0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
    end else begin
      // Bubble by default; overridden when a real result retires.
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      RDM        <= '0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_is_mul) begin
            r_a   <= RD1E;
            r_b   <= w_src_b;
            r_mac <= ALUControlE[0];
            r_grp <= '0;
          end else begin
            ALUResultM <= w_alu;
            WriteDataM <= RD2E;
            PCPlus4M   <= PCPlus4E;
            RDM        <= RDE;
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            if (ALUControlE == 3'b100) r_acc <= '0;
          end
        end
        StBusy: begin
          r_buf <= w_buf_grp;
          if (r_mac) r_acc <= w_acc_grp;
          r_grp <= r_grp + GRP_W'(1);
        end
        StDone: begin
          ALUResultM <= r_buf;
          WriteDataM <= RD2E;
          PCPlus4M   <= PCPlus4E;
          RDM        <= RDE;
          RegWriteM  <= RegWriteE;
          MemWriteM  <= MemWriteE;
          ResultSrcM <= ResultSrcE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_cycle_simd.sv
// Directed self-checking bench for execute_cycle_simd: ALU ops, branch, mul/mac
// timing, accumulator behaviour and asynchronous reset mid-operation.
module tb_execute_cycle_simd;

  logic         clk, rst;
  logic [255:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]   RDE;
  logic         RegWriteE, MemWriteE, BranchE, ALUSrcE, ResultSrcE;
  logic [2:0]   ALUControlE;
  logic         PCSrcE, StallE;
  logic [255:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]   RDM;
  logic         RegWriteM, MemWriteM, ResultSrcM;

  int n_checks = 0;
  int n_errors = 0;

  execute_cycle_simd dut (
    .clk(clk), .rst(rst), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .RDE(RDE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallE(StallE),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RDM(RDM),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rep(input logic [15:0] x);
    return {16{x}};
  endfunction

  function automatic logic [255:0] ramp(input logic [15:0] k);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[i*16 +: 16] = 16'(k * 16'(i));
    return v;
  endfunction

  task automatic drive(input logic [2:0] op, input logic [255:0] a, input logic [255:0] b,
                       input logic [255:0] imm, input logic alusrc);
    ALUControlE = op;
    RD1E        = a;
    RD2E        = b;
    ImmExtE     = imm;
    ALUSrcE     = alusrc;
  endtask

  task automatic edge_sample();
    @(negedge clk);
    #2;
  endtask

  // Full mul/mac sequence with inputs held; checks stall length, bubbles and result.
  task automatic run_mul(input string tag, input logic [255:0] exp);
    int hi;
    hi = StallE ? 1 : 0;
    check_eq({tag, "_stall_start"}, 256'(StallE), 256'(1));
    for (int e = 1; e <= 5; e++) begin
      edge_sample();
      if (StallE) hi++;
    end
    check_eq({tag, "_bubble"}, ALUResultM | 256'(RegWriteM) | 256'(RDM), '0);
    check_eq({tag, "_stall_cycles"}, 256'(hi), 256'(5));
    edge_sample();
    check_eq({tag, "_result"}, ALUResultM, exp);
    check_eq({tag, "_rdm"}, 256'(RDM), 256'(RDE));
  endtask

  initial begin
    rst = 1'b0;
    drive(3'b000, '0, '0, '0, 1'b0);
    PCE = '0; PCPlus4E = '0; RDE = '0;
    RegWriteE = 1'b0; MemWriteE = 1'b0; BranchE = 1'b0; ResultSrcE = 1'b0;
    #12;
    check_eq("reset_alu", ALUResultM, '0);
    check_eq("reset_ctrl", 256'({RegWriteM, MemWriteM, ResultSrcM, RDM}), '0);
    check_eq("reset_stall", 256'(StallE), '0);
    rst = 1'b1;

    // vadd wraps per lane
    drive(3'b000, rep(16'hFFFF), rep(16'h0002), '0, 1'b0);
    RegWriteE = 1'b1; ResultSrcE = 1'b1; RDE = 5'd5; PCPlus4E = 256'h44;
    edge_sample();
    check_eq("vadd_res", ALUResultM, rep(16'h0001));
    check_eq("vadd_ctrl", 256'({RegWriteM, MemWriteM, ResultSrcM, RDM}), 256'({3'b101, 5'd5}));
    check_eq("vadd_wd_pc4", WriteDataM ^ PCPlus4M, rep(16'h0002) ^ 256'h44);

    // and / or with immediate source
    drive(3'b010, rep(16'hF0F0), rep(16'hFF00), '0, 1'b0);
    edge_sample();
    check_eq("and", ALUResultM, rep(16'hF000));
    drive(3'b011, rep(16'hF0F0), '0, rep(16'hFF00), 1'b1);
    edge_sample();
    check_eq("or_imm", ALUResultM, rep(16'hFFF0));

    // branch on vsub zero
    drive(3'b001, 256'd5, 256'd5, 256'h20, 1'b0);
    BranchE = 1'b1; PCE = 256'h100;
    #1;
    check_eq("br_taken", 256'(PCSrcE), 256'(1));
    check_eq("br_target", PCTargetE, 256'h120);
    RD2E = 256'd6;
    #1;
    check_eq("br_not_taken", 256'(PCSrcE), '0);
    BranchE = 1'b0;
    edge_sample();

    // vmul: lane i = i * 3
    drive(3'b110, ramp(16'd1), rep(16'h0003), '0, 1'b0);
    RDE = 5'd7;
    #1;
    run_mul("vmul", ramp(16'd3));

    // vclr, then back-to-back vmac pairs
    drive(3'b100, rep(16'h1234), '0, '0, 1'b0);
    edge_sample();
    check_eq("vclr", ALUResultM, '0);
    drive(3'b111, rep(16'h0100), rep(16'h0100), '0, 1'b0);
    #1;
    run_mul("vmac_a1", '0);
    run_mul("vmac_a2", '0);
    drive(3'b111, rep(16'h00FF), rep(16'h0002), '0, 1'b0);
    #1;
    run_mul("vmac_b1", rep(16'h01FE));
    run_mul("vmac_b2", rep(16'h03FC));

    // asynchronous reset in the middle of a vmac
    drive(3'b111, rep(16'h0001), rep(16'h0001), '0, 1'b0);
    for (int e = 0; e < 3; e++) edge_sample();
    check_eq("mid_busy_stall", 256'(StallE), 256'(1));
    drive(3'b000, '0, '0, '0, 1'b0);
    rst = 1'b0;
    #1;
    check_eq("rst_mid_res", ALUResultM | WriteDataM | PCPlus4M, '0);
    check_eq("rst_mid_ctrl", 256'({RegWriteM, MemWriteM, ResultSrcM, RDM}), '0);
    check_eq("rst_mid_stall", 256'(StallE), '0);
    #2;
    rst = 1'b1;
    drive(3'b111, rep(16'h0001), rep(16'h0001), '0, 1'b0);
    #1;
    run_mul("vmac_after_rst", rep(16'h0001));

    // slt: -1 < 1, so result 1 and no branch
    drive(3'b101, 256'hFFFF_FFFF, '0, 256'd1, 1'b1);
    BranchE = 1'b1;
    #1;
    check_eq("slt_nobranch", 256'(PCSrcE), '0);
    edge_sample();
    check_eq("slt_res", ALUResultM, 256'd1);
    BranchE = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
